// File: rtl/leon_cache_stub_pkg.sv
// Shared types and constants for the LEON cache-side responder stub.
// Holds the channel state encoding, the SPARC NOP word and the wait-state range check.
package leon_stub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stub_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0100_0000;
    localparam int          WS_MAX   = 15;

    // Out-of-range wait-state settings are clamped to the 4-bit counter range.
    function automatic logic [3:0] ws_clamp(input int ws);
        if (ws < 0) begin
            return 4'd0;
        end else if (ws > WS_MAX) begin
            return 4'd15;
        end else begin
            return ws[3:0];
        end
    endfunction

endpackage

// File: rtl/leon_cache_stub_if.sv
// Agent / IU facing signal bundle of the LEON cache stub.
// The stub uses the slave view; the integer unit and agents drive the master view.
interface leon_cache_stub_if #(
    parameter int DATA_W = 32
);
    logic              iq_valid;
    logic              iq_ready;
    logic [DATA_W-1:0] iq_data;
    logic              dq_valid;
    logic              dq_ready;
    logic [DATA_W-1:0] dq_data;
    logic              ic_req;
    logic [DATA_W-1:0] ic_data;
    logic              ic_hold;
    logic              dc_req;
    logic              dc_write;
    logic [DATA_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_data;
    logic              dc_hold;
    logic              dc_mds;
    logic              sq_valid;
    logic              sq_ready;
    logic [DATA_W-1:0] sq_addr;
    logic [DATA_W-1:0] sq_data;
    logic [1:0]        underflow;

    modport slave (
        input  iq_valid, iq_data, dq_valid, dq_data, ic_req,
               dc_req, dc_write, dc_addr, dc_wdata, sq_ready,
        output iq_ready, dq_ready, ic_data, ic_hold, dc_data,
               dc_hold, dc_mds, sq_valid, sq_addr, sq_data, underflow
    );

    modport master (
        output iq_valid, iq_data, dq_valid, dq_data, ic_req,
               dc_req, dc_write, dc_addr, dc_wdata, sq_ready,
        input  iq_ready, dq_ready, ic_data, ic_hold, dc_data,
               dc_hold, dc_mds, sq_valid, sq_addr, sq_data, underflow
    );
endinterface

// File: rtl/leon_cache_stub_fifo.sv
// Power-of-two circular FIFO with valid/ready push, pop strobe and occupancy count.
// POP_FREES lets a push into a full FIFO succeed when a pop happens in the same cycle.
module leon_stub_fifo #(
    parameter int W         = 32,
    parameter int DEPTH     = 4,
    parameter bit POP_FREES = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_ready,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          pop_fire_s;
    logic          push_fire_s;

    assign full_s      = (count_r == FULL_CNT);
    assign pop_fire_s  = pop_ready && (count_r != '0);
    assign push_fire_s = push_valid && (!full_s || (POP_FREES && pop_fire_s));
    assign push_ready  = !full_s;
    assign pop_data    = mem_r[rd_ptr_r];
    assign count       = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_fire_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/leon_cache_stub.sv
// Cache-side responder for the LEON integer unit: answers fetches and loads from
// agent-filled FIFOs with configurable wait states and captures stores into a queue.
module leon_cache_stub
    import leon_stub_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                IQ_DEPTH    = 8,
    parameter int                DQ_DEPTH    = 4,
    parameter int                SQ_DEPTH    = 4,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] NOP_INST    = DATA_W'(NOP_WORD)
) (
    input logic              clk,
    input logic              rst,
    leon_cache_stub_if.slave bus
);
    localparam logic [3:0]  WS       = ws_clamp(WAIT_STATES);
    localparam stub_state_e GO_STATE = (WS == 4'd0) ? RESP : WAIT;
    localparam int          IQ_CW    = $clog2(IQ_DEPTH) + 1;
    localparam int          DQ_CW    = $clog2(DQ_DEPTH) + 1;
    localparam int          SQ_CW    = $clog2(SQ_DEPTH) + 1;

    logic                  iq_ready_s, dq_ready_s, sq_ready_in_s;
    logic [DATA_W-1:0]     iq_head_s, dq_head_s;
    logic [2*DATA_W-1:0]   sq_head_s;
    logic [IQ_CW-1:0]      iq_count_s;
    logic [DQ_CW-1:0]      dq_count_s;
    logic [SQ_CW-1:0]      sq_count_s;
    logic                  iq_avail_s, dq_avail_s, sq_valid_s, sq_can_push_s;
    logic                  iq_pop_s, dq_pop_s, sq_push_s;

    stub_state_e           ic_state_r, ic_state_s;
    logic [3:0]            ic_cnt_r, ic_cnt_s;
    logic [DATA_W-1:0]     ic_data_r, ic_data_s;
    logic                  ic_hold_r, ic_hold_s, ic_start_s;

    stub_state_e           dc_state_r, dc_state_s;
    logic [3:0]            dc_cnt_r, dc_cnt_s;
    logic [DATA_W-1:0]     dc_data_r, dc_data_s;
    logic                  dc_hold_r, dc_hold_s, dc_mds_r, dc_mds_s;
    logic                  dc_start_s, dc_done_s;
    logic                  dc_write_r;
    logic [DATA_W-1:0]     dc_addr_r, dc_wdata_r;

    logic [1:0]            uf_r;
    logic                  uf_inst_s, uf_data_s;

    leon_stub_fifo #(.W(DATA_W), .DEPTH(IQ_DEPTH), .POP_FREES(1'b0)) u_iq (
        .clk(clk), .rst(rst), .push_valid(bus.iq_valid), .push_ready(iq_ready_s),
        .push_data(bus.iq_data), .pop_ready(iq_pop_s), .pop_data(iq_head_s), .count(iq_count_s)
    );

    leon_stub_fifo #(.W(DATA_W), .DEPTH(DQ_DEPTH), .POP_FREES(1'b0)) u_dq (
        .clk(clk), .rst(rst), .push_valid(bus.dq_valid), .push_ready(dq_ready_s),
        .push_data(bus.dq_data), .pop_ready(dq_pop_s), .pop_data(dq_head_s), .count(dq_count_s)
    );

    leon_stub_fifo #(.W(2*DATA_W), .DEPTH(SQ_DEPTH), .POP_FREES(1'b1)) u_sq (
        .clk(clk), .rst(rst), .push_valid(sq_push_s), .push_ready(sq_ready_in_s),
        .push_data({dc_addr_r, dc_wdata_r}), .pop_ready(bus.sq_ready), .pop_data(sq_head_s),
        .count(sq_count_s)
    );

    assign iq_avail_s    = (iq_count_s != '0);
    assign dq_avail_s    = (dq_count_s != '0);
    assign sq_valid_s    = (sq_count_s != '0);
    // An agent pop in the same cycle makes room for a store waiting on a full queue.
    assign sq_can_push_s = sq_ready_in_s || (bus.sq_ready && sq_valid_s);

    // Fetch channel next state; a request seen while responding starts the next access.
    always_comb begin
        ic_start_s = bus.ic_req && ((ic_state_r == IDLE) || (ic_state_r == RESP));
        ic_state_s = ic_state_r;
        ic_cnt_s   = ic_cnt_r;
        ic_data_s  = ic_data_r;
        ic_hold_s  = 1'b1;
        iq_pop_s   = 1'b0;
        uf_inst_s  = uf_r[0];
        case (ic_state_r)
            IDLE: begin
                ic_cnt_s   = WS;
                ic_state_s = ic_start_s ? GO_STATE : IDLE;
            end
            WAIT: begin
                ic_hold_s  = 1'b0;
                ic_cnt_s   = ic_cnt_r - 4'd1;
                ic_state_s = (ic_cnt_r == 4'd1) ? RESP : WAIT;
            end
            RESP: begin
                iq_pop_s   = iq_avail_s;
                ic_data_s  = iq_avail_s ? iq_head_s : NOP_INST;
                uf_inst_s  = uf_r[0] | !iq_avail_s;
                ic_cnt_s   = WS;
                ic_state_s = ic_start_s ? GO_STATE : IDLE;
            end
            default: begin
                ic_state_s = IDLE;
            end
        endcase
    end

    // Data channel next state; a store stays in RESP with hold low until the queue accepts it.
    always_comb begin
        dc_done_s  = !dc_write_r || sq_can_push_s;
        dc_start_s = bus.dc_req && ((dc_state_r == IDLE) || ((dc_state_r == RESP) && dc_done_s));
        dc_state_s = dc_state_r;
        dc_cnt_s   = dc_cnt_r;
        dc_data_s  = dc_data_r;
        dc_hold_s  = 1'b1;
        dc_mds_s   = 1'b0;
        dq_pop_s   = 1'b0;
        sq_push_s  = 1'b0;
        uf_data_s  = uf_r[1];
        case (dc_state_r)
            IDLE: begin
                dc_cnt_s   = WS;
                dc_state_s = dc_start_s ? GO_STATE : IDLE;
            end
            WAIT: begin
                dc_hold_s  = 1'b0;
                dc_cnt_s   = dc_cnt_r - 4'd1;
                dc_state_s = (dc_cnt_r == 4'd1) ? RESP : WAIT;
            end
            RESP: begin
                if (dc_write_r) begin
                    sq_push_s = sq_can_push_s;
                    dc_hold_s = sq_can_push_s;
                end else begin
                    dq_pop_s  = dq_avail_s;
                    dc_data_s = dq_avail_s ? dq_head_s : '0;
                    dc_mds_s  = 1'b1;
                    uf_data_s = uf_r[1] | !dq_avail_s;
                end
                dc_cnt_s   = WS;
                dc_state_s = dc_start_s ? GO_STATE : (dc_done_s ? IDLE : RESP);
            end
            default: begin
                dc_state_s = IDLE;
            end
        endcase
    end

    // State, registered outputs and the access captured at request time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ic_state_r <= IDLE;
            ic_cnt_r   <= 4'd0;
            ic_data_r  <= NOP_INST;
            ic_hold_r  <= 1'b1;
            dc_state_r <= IDLE;
            dc_cnt_r   <= 4'd0;
            dc_data_r  <= '0;
            dc_hold_r  <= 1'b1;
            dc_mds_r   <= 1'b0;
            dc_write_r <= 1'b0;
            dc_addr_r  <= '0;
            dc_wdata_r <= '0;
            uf_r       <= 2'b00;
        end else begin
            ic_state_r <= ic_state_s;
            ic_cnt_r   <= ic_cnt_s;
            ic_data_r  <= ic_data_s;
            ic_hold_r  <= ic_hold_s;
            dc_state_r <= dc_state_s;
            dc_cnt_r   <= dc_cnt_s;
            dc_data_r  <= dc_data_s;
            dc_hold_r  <= dc_hold_s;
            dc_mds_r   <= dc_mds_s;
            uf_r       <= {uf_data_s, uf_inst_s};
            if (dc_start_s) begin
                dc_write_r <= bus.dc_write;
                dc_addr_r  <= bus.dc_addr;
                dc_wdata_r <= bus.dc_wdata;
            end
        end
    end

    assign bus.iq_ready  = iq_ready_s;
    assign bus.dq_ready  = dq_ready_s;
    assign bus.ic_data   = ic_data_r;
    assign bus.ic_hold   = ic_hold_r;
    assign bus.dc_data   = dc_data_r;
    assign bus.dc_hold   = dc_hold_r;
    assign bus.dc_mds    = dc_mds_r;
    assign bus.sq_valid  = sq_valid_s;
    assign bus.sq_addr   = sq_head_s[2*DATA_W-1:DATA_W];
    assign bus.sq_data   = sq_head_s[DATA_W-1:0];
    assign bus.underflow = uf_r;

endmodule

// File: tb/tb_leon_cache_stub.sv
// Self-checking bench for leon_cache_stub: one instance with no wait states, one with three,
// sharing a stimulus bus; a queue-based model predicts every response.
module tb_leon_cache_stub;

    localparam logic [31:0] NOP = 32'h0100_0000;

    logic clk;
    logic rst;
    logic sel;
    int   ws;
    int   checks;
    int   errors;

    logic        iq_valid, dq_valid, ic_req, dc_req, dc_write, sq_ready;
    logic [31:0] iq_data, dq_data, dc_addr, dc_wdata;

    logic        o_iq_ready, o_dq_ready, o_ic_hold, o_dc_hold, o_dc_mds, o_sq_valid;
    logic [31:0] o_ic_data, o_dc_data, o_sq_addr, o_sq_data;
    logic [1:0]  o_uf;

    logic [31:0] iq_m[$];
    logic [31:0] dq_m[$];
    logic [63:0] sq_m[$];
    logic [1:0]  uf_m;

    leon_cache_stub_if #(.DATA_W(32)) if0 ();
    leon_cache_stub_if #(.DATA_W(32)) if3 ();

    leon_cache_stub #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    leon_cache_stub #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.iq_valid = iq_valid & ~sel;
    assign if3.iq_valid = iq_valid & sel;
    assign if0.dq_valid = dq_valid & ~sel;
    assign if3.dq_valid = dq_valid & sel;
    assign if0.ic_req   = ic_req & ~sel;
    assign if3.ic_req   = ic_req & sel;
    assign if0.dc_req   = dc_req & ~sel;
    assign if3.dc_req   = dc_req & sel;
    assign if0.sq_ready = sq_ready & ~sel;
    assign if3.sq_ready = sq_ready & sel;
    assign if0.iq_data  = iq_data;
    assign if3.iq_data  = iq_data;
    assign if0.dq_data  = dq_data;
    assign if3.dq_data  = dq_data;
    assign if0.dc_write = dc_write;
    assign if3.dc_write = dc_write;
    assign if0.dc_addr  = dc_addr;
    assign if3.dc_addr  = dc_addr;
    assign if0.dc_wdata = dc_wdata;
    assign if3.dc_wdata = dc_wdata;

    assign o_iq_ready = sel ? if3.iq_ready  : if0.iq_ready;
    assign o_dq_ready = sel ? if3.dq_ready  : if0.dq_ready;
    assign o_ic_data  = sel ? if3.ic_data   : if0.ic_data;
    assign o_ic_hold  = sel ? if3.ic_hold   : if0.ic_hold;
    assign o_dc_data  = sel ? if3.dc_data   : if0.dc_data;
    assign o_dc_hold  = sel ? if3.dc_hold   : if0.dc_hold;
    assign o_dc_mds   = sel ? if3.dc_mds    : if0.dc_mds;
    assign o_sq_valid = sel ? if3.sq_valid  : if0.sq_valid;
    assign o_sq_addr  = sel ? if3.sq_addr   : if0.sq_addr;
    assign o_sq_data  = sel ? if3.sq_data   : if0.sq_data;
    assign o_uf       = sel ? if3.underflow : if0.underflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut ws=%0d) got %0h expected %0h at %0t", name, ws, act, exp, $time);
        end
    endtask

    task automatic pick(input logic s);
        sel = s;
        ws  = s ? 3 : 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        iq_m.delete();
        dq_m.delete();
        sq_m.delete();
        uf_m = 2'b00;
    endtask

    task automatic check_reset_values();
        chk("rst_ic_data", o_ic_data, NOP);
        chk("rst_ic_hold", o_ic_hold, 1'b1);
        chk("rst_dc_data", o_dc_data, 32'h0);
        chk("rst_dc_hold", o_dc_hold, 1'b1);
        chk("rst_dc_mds", o_dc_mds, 1'b0);
        chk("rst_sq_valid", o_sq_valid, 1'b0);
        chk("rst_underflow", o_uf, 2'b00);
        chk("rst_iq_ready", o_iq_ready, 1'b1);
        chk("rst_dq_ready", o_dq_ready, 1'b1);
    endtask

    task automatic push_iq(input logic [31:0] d);
        iq_valid = 1'b1;
        iq_data  = d;
        @(negedge clk);
        iq_valid = 1'b0;
    endtask

    task automatic push_dq(input logic [31:0] d);
        dq_valid = 1'b1;
        dq_data  = d;
        @(negedge clk);
        dq_valid = 1'b0;
    endtask

    // One request cycle, ws stall cycles, the response cycle, then one idle cycle.
    task automatic access(input bit f, input bit d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_ic,
                          input logic [31:0] exp_dc, input logic [1:0] exp_uf);
        ic_req   = f;
        dc_req   = d;
        dc_write = w;
        dc_addr  = a;
        dc_wdata = wd;
        @(negedge clk);
        ic_req   = 1'b0;
        dc_req   = 1'b0;
        dc_write = 1'b0;
        dc_addr  = $urandom;
        dc_wdata = $urandom;
        for (int i = 0; i < ws; i++) begin
            @(negedge clk);
            if (f) chk("ic_hold_wait", o_ic_hold, 1'b0);
            if (d) chk("dc_hold_wait", o_dc_hold, 1'b0);
            if (d) chk("dc_mds_wait", o_dc_mds, 1'b0);
        end
        @(negedge clk);
        if (f) begin
            chk("ic_hold_resp", o_ic_hold, 1'b1);
            chk("ic_data_resp", o_ic_data, exp_ic);
        end
        if (d) begin
            chk("dc_hold_resp", o_dc_hold, 1'b1);
            chk("dc_mds_resp", o_dc_mds, !w);
            if (!w) chk("dc_data_resp", o_dc_data, exp_dc);
        end
        chk("underflow", o_uf, exp_uf);
        @(negedge clk);
        chk("dc_mds_after", o_dc_mds, 1'b0);
    endtask

    task automatic run_random(input int n);
        logic [31:0] d, ei, ed, a;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 5))
                0: begin
                    d = $urandom;
                    chk("iq_ready", o_iq_ready, iq_m.size() < 8);
                    if (iq_m.size() < 8) iq_m.push_back(d);
                    push_iq(d);
                end
                1: begin
                    d = $urandom;
                    chk("dq_ready", o_dq_ready, dq_m.size() < 4);
                    if (dq_m.size() < 4) dq_m.push_back(d);
                    push_dq(d);
                end
                2, 3, 4: begin
                    ei = NOP;
                    ed = 32'h0;
                    if (k % 3 != 1) begin
                        if (iq_m.size() > 0) ei = iq_m.pop_front();
                        else uf_m[0] = 1'b1;
                    end
                    if (k % 3 != 0) begin
                        if (dq_m.size() > 0) ed = dq_m.pop_front();
                        else uf_m[1] = 1'b1;
                    end
                    access(k % 3 != 1, k % 3 != 0, 1'b0, 32'h0, 32'h0, ei, ed, uf_m);
                end
                default: begin
                    if (sq_m.size() < 4 && $urandom_range(0, 1) == 1) begin
                        a = $urandom;
                        d = $urandom;
                        access(1'b0, 1'b1, 1'b1, a, d, 32'h0, 32'h0, uf_m);
                        sq_m.push_back({a, d});
                    end else begin
                        chk("sq_valid", o_sq_valid, sq_m.size() > 0);
                        if (sq_m.size() > 0) begin
                            chk("sq_entry", {o_sq_addr, o_sq_data}, sq_m[0]);
                            void'(sq_m.pop_front());
                        end
                        sq_ready = 1'b1;
                        @(negedge clk);
                        sq_ready = 1'b0;
                    end
                end
            endcase
        end
    endtask

    typedef struct {
        logic        iq_v;
        logic [31:0] iq_d;
        logic        req;
        logic [31:0] exp_data;
        logic [1:0]  exp_uf;
    } fvec_t;

    fvec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 32'h8200_6001, 1'b0, NOP,          2'b00};
        tbl[1] = '{1'b1, 32'h8400_8001, 1'b0, NOP,          2'b00};
        tbl[2] = '{1'b1, 32'h8601_0002, 1'b0, NOP,          2'b00};
        tbl[3] = '{1'b0, 32'h0,         1'b1, NOP,          2'b00};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 32'h8200_6001, 2'b00};
        tbl[5] = '{1'b0, 32'h0,         1'b1, 32'h8400_8001, 2'b00};
        tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h8601_0002, 2'b00};
        tbl[7] = '{1'b0, 32'h0,         1'b1, 32'h8601_0002, 2'b00};
        tbl[8] = '{1'b0, 32'h0,         1'b0, NOP,          2'b01};
        tbl[9] = '{1'b0, 32'h0,         1'b0, NOP,          2'b01};

        checks   = 0;
        errors   = 0;
        iq_valid = 1'b0; dq_valid = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
        dc_write = 1'b0; sq_ready = 1'b0;
        iq_data  = 32'h0; dq_data = 32'h0; dc_addr = 32'h0; dc_wdata = 32'h0;
        pick(1'b0);
        rst = 1'b0;
        @(negedge clk);
        do_reset();
        pick(1'b0);
        check_reset_values();
        pick(1'b1);
        check_reset_values();

        // In-order fetch, back-to-back requests, then underflow to NOP.
        pick(1'b0);
        for (int i = 0; i < 10; i++) begin
            iq_valid = tbl[i].iq_v;
            iq_data  = tbl[i].iq_d;
            ic_req   = tbl[i].req;
            @(negedge clk);
            chk("tbl_ic_data", o_ic_data, tbl[i].exp_data);
            chk("tbl_ic_hold", o_ic_hold, 1'b1);
            chk("tbl_underflow", o_uf, tbl[i].exp_uf);
        end
        iq_valid = 1'b0;
        ic_req   = 1'b0;

        // Three wait states before the load data and its strobe.
        pick(1'b1);
        push_dq(32'h0000_0100);
        access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0100, 2'b00);

        // Store queue fills; the fifth store stalls until a pop frees a slot.
        pick(1'b0);
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 32'h0, 32'h0, 2'b01);
        end
        dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'h1010; dc_wdata = 32'hA4;
        @(negedge clk);
        dc_req = 1'b0; dc_write = 1'b0; dc_addr = 32'h0; dc_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_dc_hold", o_dc_hold, 1'b0);
        end
        sq_ready = 1'b1;
        @(negedge clk);
        sq_ready = 1'b0;
        chk("unstall_dc_hold", o_dc_hold, 1'b1);
        for (int i = 1; i < 5; i++) begin
            chk("drain_sq_valid", o_sq_valid, 1'b1);
            chk("drain_sq_addr", o_sq_addr, 32'h1000 + 32'(4 * i));
            chk("drain_sq_data", o_sq_data, 32'hA0 + 32'(i));
            sq_ready = 1'b1;
            @(negedge clk);
            sq_ready = 1'b0;
        end
        chk("drained_sq_valid", o_sq_valid, 1'b0);

        // Randomised traffic against the queue model on both instances.
        for (int s = 0; s < 2; s++) begin
            pick(s[0]);
            do_reset();
            run_random(150);
        end

        // Reset asserted while a load is waiting.
        pick(1'b1);
        do_reset();
        push_dq(32'h55);
        push_iq(32'h1234);
        dc_req = 1'b1;
        @(negedge clk);
        dc_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_dc_hold", o_dc_hold, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_mds", o_dc_mds, 1'b0);
            chk("post_rst_hold", o_dc_hold, 1'b1);
        end
        access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, NOP, 32'h0, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
